bcd_chain_ctrl: RTL and testbench
=================================

# bcd_chain_ctrl

Controller and sequencer for a cascade of BCD digit counters. It accepts start, stop, clear and snapshot commands over a valid/ready handshake, advances the digit chain on a prescaled tick, and stops with a one-cycle `done` pulse when the count reaches a programmed BCD terminal value. It sits between the system command logic and the display path; `snap` feeds the display/update logic.

## Interface
- `DIGITS`, default 4: number of cascaded BCD digits; must be at least 1.
- `PRESC`, default 1: the count advances once every `PRESC` cycles while running; must be at least 1.
- `clk` in 1: the single clock; all state changes on its rising edge.
- `rst` in 1: reset, asynchronous and active-high.
- `cmd_valid` in 1: command request.
- `cmd_ready` out 1: the block can accept a command (combinational from state).
- `cmd_op` in 2: command opcode; 00 START, 01 STOP, 10 CLEAR, 11 SNAP.
- `limit` in 4*DIGITS: BCD terminal value; latched into `limit_q` when a START is accepted.
- `count` out 4*DIGITS: live BCD count; digit 0 is bits [3:0].
- `snap` out 4*DIGITS: latched copy of `count`.
- `snap_valid` out 1: one-cycle pulse after a snapshot is taken.
- `running` out 1: high while the state is RUN.
- `done` out 1: one-cycle pulse when the terminal value is reached.

## Operation
- A command is accepted on a rising edge when `cmd_valid & cmd_ready`. `cmd_ready` is 1 in IDLE, RUN and PAUSE, and 0 in FINISH.
- States and transitions:
  - IDLE:
    - START: latch `limit`, clear the prescaler, go to RUN.
    - CLEAR: `count` becomes 0.
    - STOP: no effect.
  - RUN:
    - A tick occurs when the prescaler reaches `PRESC`-1; the prescaler then wraps to 0.
    - On each tick `count` increments by 1 in BCD. A digit rolls 9→0 and carries into the next digit; all 9s wrap to all 0s.
    - If the incremented value equals `limit_q`, go to FINISH.
    - STOP: go to PAUSE; `count` and the prescaler hold.
    - CLEAR: `count` and the prescaler become 0; stay in RUN.
  - PAUSE:
    - START: re-latch `limit`, go to RUN; the prescaler is not cleared.
    - CLEAR: `count` becomes 0, go to IDLE.
  - FINISH: lasts one cycle with `done`=1, then goes to IDLE. `count` holds at the limit.
- SNAP is valid in any state where a command is accepted:
  - `snap` captures `count` as it was before any same-edge increment.
  - `snap_valid` is 1 for exactly the next cycle.
  - The state does not change.
- CLEAR on the same edge as a tick: the clear wins.
- If `limit_q` equals `count` at START, the block runs a full 10^DIGITS ticks before finishing.
- A limit digit greater than 9 never matches; the block then free-runs and wraps until STOP or CLEAR.
- Reset mid-operation returns to IDLE immediately.

## Timing
- Reset values:
  - `count` = 0, `snap` = 0, `snap_valid` = 0, `running` = 0, `done` = 0, `limit_q` = 0, prescaler = 0.
  - State is IDLE, so `cmd_ready` = 1.
- All outputs are registered except `cmd_ready`.
- START accepted at edge k: `running` is 1 from k, and the first increment happens at edge k+`PRESC`.
- The increment that reaches the limit at edge m sets `done` and clears `running` from m. At m+1 the state is IDLE and `cmd_ready` is 1.
- SNAP accepted at edge k: `snap` and `snap_valid` are updated at k.
- Increment carry ripples combinationally through the chain within one cycle; there is no per-digit latency.

## Structure
- Package `bcd_ctrl_pkg`:
  - state enum (IDLE, RUN, PAUSE, FINISH);
  - opcode constants (CMD_START, CMD_STOP, CMD_CLEAR, CMD_SNAP);
  - `BCD_MAX` = 4'd9.
- Sub-module `bcd_digit`, instantiated `DIGITS` times in a generate loop:
  - inputs `clk`, `rst`, `clr`, `en_in`;
  - outputs `digit[3:0]` and `en_out` = `en_in` & (`digit` == 9).
  - Chain digit i's `en_out` to digit i+1's `en_in`; digit 0's `en_in` is the tick.
- The FSM, prescaler, limit compare and snapshot register live in `bcd_chain_ctrl`.

## Test plan
All scenarios use `DIGITS`=2.
- `PRESC`=1, START with `limit`=0x12 from 0 → `count` steps 01…12 on consecutive edges; `done` is 1 for one cycle at 0x12; `running` then falls; `count` holds 0x12; `cmd_ready` is 0 for that cycle.
- `PRESC`=1, START with `limit`=0x00 from 0 → `count` wraps 0x99→0x00 on tick 100; `done` pulses once.
- STOP accepted at `count`=0x07 → `count` holds 0x07 for 10 cycles with `running`=0; START with `limit`=0x09 → 0x08 then 0x09, then `done`.
- SNAP during RUN when `count`=0x33 → `snap`=0x33 and `snap_valid` high for one cycle; `count` continues to 0x34.
- `PRESC`=3, START → increments every 3 cycles; CLEAR at `count`=0x04 → `count`=0x00, `running` stays 1, next increment 3 cycles later; STOP, then CLEAR in PAUSE → IDLE with `count` 0.
- Assert `rst` asynchronously mid-RUN at `count`=0x21 → every output is 0 and `cmd_ready`=1 before the next edge; command with `cmd_valid`=1 during FINISH → ignored.

Source files
------------

// File: rtl/bcd_ctrl_pkg.sv
// Shared types and constants for the BCD chain controller.
//   state_t       : controller FSM states
//   CMD_*         : command opcodes carried on cmd_op
//   BCD_MAX       : largest legal BCD digit value
package bcd_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSE  = 2'd2,
        FINISH = 2'd3
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_CLEAR = 2'b10;
    localparam logic [1:0] CMD_SNAP  = 2'b11;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Value a digit takes after this edge, given its own carry-in and carry-out.
    function automatic logic [3:0] bcd_digit_next(input logic [3:0] d,
                                                  input logic       en_in,
                                                  input logic       en_out);
        logic [3:0] nxt;
        if (en_out) begin
            nxt = 4'd0;
        end else if (en_in) begin
            nxt = d + 4'd1;
        end else begin
            nxt = d;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/bcd_digit.sv
// One decade of the BCD counter chain.
//   clk, rst : clock, asynchronous active-high reset
//   clr      : synchronous clear to 0 (dominates en_in)
//   en_in    : carry/enable from the previous digit (or the tick for digit 0)
//   digit    : registered BCD value 0..9
//   en_out   : carry to the next digit, en_in while this digit sits at 9
module bcd_digit
    import bcd_ctrl_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clr,
    input  logic       en_in,
    output logic [3:0] digit,
    output logic       en_out
);

    // Digit register: clear wins, otherwise count 0..9 and roll over.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            digit <= 4'd0;
        end else if (clr) begin
            digit <= 4'd0;
        end else if (en_in) begin
            digit <= (digit == BCD_MAX) ? 4'd0 : digit + 4'd1;
        end else begin
            digit <= digit;
        end
    end

    assign en_out = en_in & (digit == BCD_MAX);

endmodule

// File: rtl/bcd_chain_ctrl.sv
// Command-driven sequencer for a cascade of BCD digit counters.
//   DIGITS     : number of BCD digits (>= 1)
//   PRESC      : count advances once every PRESC cycles while running (>= 1)
//   clk, rst   : clock, asynchronous active-high reset
//   cmd_valid, cmd_ready, cmd_op : command handshake (START/STOP/CLEAR/SNAP)
//   limit      : BCD terminal value, captured on an accepted START
//   count      : live BCD count, digit 0 in bits [3:0]
//   snap, snap_valid : captured count and its one-cycle strobe
//   running    : high while in RUN
//   done       : one-cycle pulse when the count reaches the terminal value
module bcd_chain_ctrl
    import bcd_ctrl_pkg::*;
#(
    parameter int DIGITS = 4,
    parameter int PRESC  = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [1:0]            cmd_op,
    input  logic [4*DIGITS-1:0]   limit,
    output logic [4*DIGITS-1:0]   count,
    output logic [4*DIGITS-1:0]   snap,
    output logic                  snap_valid,
    output logic                  running,
    output logic                  done
);

    localparam int W  = 4 * DIGITS;
    localparam int PW = (PRESC > 1) ? $clog2(PRESC) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(PRESC - 1);

    state_t          state_r;
    logic [PW-1:0]   presc_r;
    logic [W-1:0]    limit_q_r;
    logic [W-1:0]    snap_r;
    logic            snap_valid_r;
    logic            running_r;
    logic            done_r;

    logic            accept_s;
    logic            start_s;
    logic            stop_s;
    logic            clear_s;
    logic            snap_cmd_s;
    logic            tick_raw_s;
    logic            tick_s;
    logic            reach_s;
    logic [DIGITS-1:0] en_in_s;
    logic [DIGITS-1:0] en_out_s;
    logic [W-1:0]    next_count_s;

    assign cmd_ready  = (state_r != FINISH);
    assign accept_s   = cmd_valid & cmd_ready;
    assign start_s    = accept_s & (cmd_op == CMD_START);
    assign stop_s     = accept_s & (cmd_op == CMD_STOP);
    assign clear_s    = accept_s & (cmd_op == CMD_CLEAR);
    assign snap_cmd_s = accept_s & (cmd_op == CMD_SNAP);

    // A STOP or CLEAR on the tick edge suppresses the increment.
    assign tick_raw_s = (state_r == RUN) & (presc_r == PRESC_LAST);
    assign tick_s     = tick_raw_s & ~stop_s & ~clear_s;

    // Digit chain with combinational carry ripple; next_count_s mirrors
    // what the digits will hold after this edge, for the limit compare.
    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            if (gi == 0) begin : g_first
                assign en_in_s[gi] = tick_s;
            end else begin : g_rest
                assign en_in_s[gi] = en_out_s[gi-1];
            end

            bcd_digit u_digit (
                .clk    (clk),
                .rst    (rst),
                .clr    (clear_s),
                .en_in  (en_in_s[gi]),
                .digit  (count[4*gi +: 4]),
                .en_out (en_out_s[gi])
            );

            assign next_count_s[4*gi +: 4] =
                bcd_digit_next(count[4*gi +: 4], en_in_s[gi], en_out_s[gi]);
        end
    endgenerate

    // Comparing the post-increment value means a limit equal to the start
    // count needs a full wrap, and a limit digit above 9 never matches.
    assign reach_s = tick_s & (next_count_s == limit_q_r);

    // Controller FSM, prescaler, limit latch and snapshot register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r      <= IDLE;
            presc_r      <= '0;
            limit_q_r    <= '0;
            snap_r       <= '0;
            snap_valid_r <= 1'b0;
            running_r    <= 1'b0;
            done_r       <= 1'b0;
        end else begin
            done_r       <= 1'b0;
            snap_valid_r <= snap_cmd_s;
            if (snap_cmd_s) begin
                snap_r <= count;
            end
            case (state_r)
                IDLE: begin
                    if (start_s) begin
                        limit_q_r <= limit;
                        presc_r   <= '0;
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end
                end
                RUN: begin
                    if (clear_s) begin
                        presc_r <= '0;
                    end else if (stop_s) begin
                        state_r   <= PAUSE;
                        running_r <= 1'b0;
                    end else begin
                        presc_r <= tick_raw_s ? '0 : presc_r + PW'(1);
                        if (reach_s) begin
                            state_r   <= FINISH;
                            running_r <= 1'b0;
                            done_r    <= 1'b1;
                        end
                    end
                end
                PAUSE: begin
                    // Prescaler keeps its phase across the pause.
                    if (start_s) begin
                        limit_q_r <= limit;
                        state_r   <= RUN;
                        running_r <= 1'b1;
                    end else if (clear_s) begin
                        state_r <= IDLE;
                    end
                end
                FINISH: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r   <= IDLE;
                    running_r <= 1'b0;
                end
            endcase
        end
    end

    assign snap       = snap_r;
    assign snap_valid = snap_valid_r;
    assign running    = running_r;
    assign done       = done_r;

endmodule

// File: tb/tb_bcd_chain_ctrl.sv
// Directed bench for bcd_chain_ctrl with two 2-digit instances (PRESC=1 and
// PRESC=3) sharing the command inputs; each phase checks one of them.
module tb_bcd_chain_ctrl;

    localparam logic [1:0] OP_START = 2'b00;
    localparam logic [1:0] OP_STOP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;
    localparam logic [1:0] OP_SNAP  = 2'b11;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       cmd_valid = 1'b0;
    logic [1:0] cmd_op = 2'b00;
    logic [7:0] limit = 8'h00;

    logic       c1_ready, c1_snapv, c1_run, c1_done;
    logic [7:0] c1_count, c1_snap;
    logic       c3_ready, c3_snapv, c3_run, c3_done;
    logic [7:0] c3_count, c3_snap;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    bcd_chain_ctrl #(.DIGITS(2), .PRESC(1)) dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(c1_ready),
        .cmd_op(cmd_op), .limit(limit), .count(c1_count), .snap(c1_snap),
        .snap_valid(c1_snapv), .running(c1_run), .done(c1_done)
    );

    bcd_chain_ctrl #(.DIGITS(2), .PRESC(3)) dut3 (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(c3_ready),
        .cmd_op(cmd_op), .limit(limit), .count(c3_count), .snap(c3_snap),
        .snap_valid(c3_snapv), .running(c3_run), .done(c3_done)
    );

    typedef struct {
        logic       v;
        logic [1:0] op;
        logic [7:0] lim;
        logic [7:0] e_count;
        logic       e_run;
        logic       e_done;
        logic       e_rdy;
    } vec_t;

    vec_t vecs [15];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // One command cycle: drive at negedge, sample 1 time unit after posedge.
    task automatic cyc(input logic v, input logic [1:0] op, input logic [7:0] lim);
        @(negedge clk);
        cmd_valid = v;
        cmd_op    = op;
        limit     = lim;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    function automatic logic [7:0] bcd2(input int v);
        logic [3:0] hi;
        logic [3:0] lo;
        hi = 4'(v / 10);
        lo = 4'(v % 10);
        return {hi, lo};
    endfunction

    initial begin
        int n_done;

        // Table: START limit 0x12, count 01..12, done pulse, ignored cmd in FINISH.
        vecs[0] = '{1'b1, OP_START, 8'h12, 8'h00, 1'b1, 1'b0, 1'b1};
        for (int i = 1; i <= 11; i++) begin
            vecs[i] = '{1'b0, OP_START, 8'h00, bcd2(i), 1'b1, 1'b0, 1'b1};
        end
        vecs[12] = '{1'b0, OP_START, 8'h00, 8'h12, 1'b0, 1'b1, 1'b0};
        vecs[13] = '{1'b1, OP_START, 8'h05, 8'h12, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, OP_START, 8'h00, 8'h12, 1'b0, 1'b0, 1'b1};

        // Reset state.
        #12;
        chk("rst_count", c1_count, 8'h00);
        chk("rst_snap", c1_snap, 8'h00);
        chk("rst_snapv", c1_snapv, 1'b0);
        chk("rst_running", c1_run, 1'b0);
        chk("rst_done", c1_done, 1'b0);
        chk("rst_ready", c1_ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 15; i++) begin
            cyc(vecs[i].v, vecs[i].op, vecs[i].lim);
            chk($sformatf("vec%0d_count", i), c1_count, vecs[i].e_count);
            chk($sformatf("vec%0d_running", i), c1_run, vecs[i].e_run);
            chk($sformatf("vec%0d_done", i), c1_done, vecs[i].e_done);
            chk($sformatf("vec%0d_ready", i), c1_ready, vecs[i].e_rdy);
        end

        // Limit equal to start count: full 100-tick wrap.
        cyc(1'b1, OP_CLEAR, 8'h00);
        chk("idle_clear_count", c1_count, 8'h00);
        cyc(1'b1, OP_START, 8'h00);
        n_done = 0;
        for (int n = 1; n <= 110; n++) begin
            cyc(1'b0, OP_START, 8'h00);
            if (n == 99) chk("wrap_at_99", c1_count, 8'h99);
            if (c1_done) begin
                n_done = n;
                break;
            end
        end
        chk("wrap_tick_index", n_done, 100);
        chk("wrap_count", c1_count, 8'h00);
        cyc(1'b0, OP_START, 8'h00);
        chk("wrap_done_single", c1_done, 1'b0);

        // STOP at 0x07, hold 10 cycles, resume to limit 0x09.
        cyc(1'b1, OP_START, 8'h50);
        for (int n = 0; n < 7; n++) cyc(1'b0, OP_START, 8'h00);
        chk("pre_stop_count", c1_count, 8'h07);
        cyc(1'b1, OP_STOP, 8'h00);
        chk("stop_count", c1_count, 8'h07);
        chk("stop_running", c1_run, 1'b0);
        for (int n = 0; n < 10; n++) begin
            cyc(1'b0, OP_START, 8'h00);
            chk("pause_hold_count", c1_count, 8'h07);
            chk("pause_running", c1_run, 1'b0);
        end
        cyc(1'b1, OP_START, 8'h09);
        chk("resume_running", c1_run, 1'b1);
        chk("resume_count", c1_count, 8'h07);
        cyc(1'b0, OP_START, 8'h00);
        chk("resume_08", c1_count, 8'h08);
        cyc(1'b0, OP_START, 8'h00);
        chk("resume_09", c1_count, 8'h09);
        chk("resume_done", c1_done, 1'b1);
        cyc(1'b0, OP_START, 8'h00);
        chk("resume_done_end", c1_done, 1'b0);

        // SNAP at 0x33 during RUN.
        cyc(1'b1, OP_CLEAR, 8'h00);
        cyc(1'b1, OP_START, 8'h99);
        for (int n = 0; n < 33; n++) cyc(1'b0, OP_START, 8'h00);
        chk("pre_snap_count", c1_count, 8'h33);
        cyc(1'b1, OP_SNAP, 8'h00);
        chk("snap_value", c1_snap, 8'h33);
        chk("snap_valid", c1_snapv, 1'b1);
        chk("snap_count_moves", c1_count, 8'h34);
        cyc(1'b0, OP_START, 8'h00);
        chk("snap_valid_drop", c1_snapv, 1'b0);
        chk("snap_hold", c1_snap, 8'h33);
        chk("snap_count_35", c1_count, 8'h35);

        // CLEAR in RUN, then asynchronous reset at 0x21.
        cyc(1'b1, OP_CLEAR, 8'h00);
        chk("run_clear_count", c1_count, 8'h00);
        chk("run_clear_running", c1_run, 1'b1);
        for (int n = 0; n < 21; n++) cyc(1'b0, OP_START, 8'h00);
        chk("pre_rst_count", c1_count, 8'h21);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("arst_count", c1_count, 8'h00);
        chk("arst_snap", c1_snap, 8'h00);
        chk("arst_snapv", c1_snapv, 1'b0);
        chk("arst_running", c1_run, 1'b0);
        chk("arst_done", c1_done, 1'b0);
        chk("arst_ready", c1_ready, 1'b1);
        #1;
        rst = 1'b0;

        // PRESC=3 instance: slow ticks, CLEAR in RUN, STOP then CLEAR in PAUSE.
        cyc(1'b1, OP_START, 8'h99);
        chk("p3_start_count", c3_count, 8'h00);
        chk("p3_start_running", c3_run, 1'b1);
        for (int n = 1; n <= 12; n++) begin
            cyc(1'b0, OP_START, 8'h00);
            chk($sformatf("p3_step%0d", n), c3_count, bcd2(n / 3));
        end
        cyc(1'b1, OP_CLEAR, 8'h00);
        chk("p3_clear_count", c3_count, 8'h00);
        chk("p3_clear_running", c3_run, 1'b1);
        cyc(1'b0, OP_START, 8'h00);
        chk("p3_after_clear_1", c3_count, 8'h00);
        cyc(1'b0, OP_START, 8'h00);
        chk("p3_after_clear_2", c3_count, 8'h00);
        cyc(1'b0, OP_START, 8'h00);
        chk("p3_after_clear_3", c3_count, 8'h01);
        cyc(1'b1, OP_STOP, 8'h00);
        chk("p3_stop_running", c3_run, 1'b0);
        chk("p3_stop_count", c3_count, 8'h01);
        cyc(1'b1, OP_CLEAR, 8'h00);
        chk("p3_pause_clear_count", c3_count, 8'h00);
        chk("p3_pause_clear_running", c3_run, 1'b0);
        chk("p3_pause_clear_ready", c3_ready, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

endmodule
